// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller with instruction register and decode.
// It owns the IDCODE and BYPASS data registers and the TDO mux.
module jtag_tap_ctrl #(
    parameter int                IR_LEN     = 4,
    parameter logic [31:0]       IDCODE_VAL = 32'h1180_0001,
    parameter logic [IR_LEN-1:0] OP_EXTEST  = 4'h0,
    parameter logic [IR_LEN-1:0] OP_SAMPLE  = 4'h1,
    parameter logic [IR_LEN-1:0] OP_IDCODE  = 4'h2,
    parameter logic [IR_LEN-1:0] OP_MBIST   = 4'h8,
    parameter logic [IR_LEN-1:0] OP_DEBUG   = 4'h9,
    parameter logic [IR_LEN-1:0] OP_BYPASS  = 4'hF
) (
    input  logic tck_i,
    input  logic trst_i,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic bs_chain_tdo_i,
    input  logic mbist_tdo_i,
    input  logic debug_tdo_i,
    output logic tdo_o,
    output logic tdo_en_o,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic extest_select_o,
    output logic sample_preload_select_o,
    output logic mbist_select_o,
    output logic debug_select_o,
    output logic idcode_select_o,
    output logic bypass_select_o
);

    localparam logic [3:0] ST_TLR   = 4'hF;
    localparam logic [3:0] ST_RTI   = 4'hC;
    localparam logic [3:0] ST_SELDR = 4'h7;
    localparam logic [3:0] ST_CAPDR = 4'h6;
    localparam logic [3:0] ST_SHDR  = 4'h2;
    localparam logic [3:0] ST_EX1DR = 4'h1;
    localparam logic [3:0] ST_PAUDR = 4'h3;
    localparam logic [3:0] ST_EX2DR = 4'h0;
    localparam logic [3:0] ST_UPDDR = 4'h5;
    localparam logic [3:0] ST_SELIR = 4'h4;
    localparam logic [3:0] ST_CAPIR = 4'hE;
    localparam logic [3:0] ST_SHIR  = 4'hA;
    localparam logic [3:0] ST_EX1IR = 4'h9;
    localparam logic [3:0] ST_PAUIR = 4'hB;
    localparam logic [3:0] ST_EX2IR = 4'h8;
    localparam logic [3:0] ST_UPDIR = 4'hD;

    logic [3:0]        state_r;
    logic [3:0]        next_state_s;
    logic [IR_LEN-1:0] ir_r;
    logic [IR_LEN-1:0] ir_shift_r;
    logic              bypass_r;
    logic [31:0]       idcode_shift_r;
    logic              tdo_s;

    // TAP state transition function on TMS
    always_comb begin
        next_state_s = ST_TLR;
        case (state_r)
            ST_TLR:   next_state_s = tms_i ? ST_TLR   : ST_RTI;
            ST_RTI:   next_state_s = tms_i ? ST_SELDR : ST_RTI;
            ST_SELDR: next_state_s = tms_i ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: next_state_s = tms_i ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  next_state_s = tms_i ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: next_state_s = tms_i ? ST_UPDDR : ST_PAUDR;
            ST_PAUDR: next_state_s = tms_i ? ST_EX2DR : ST_PAUDR;
            ST_EX2DR: next_state_s = tms_i ? ST_UPDDR : ST_SHDR;
            ST_UPDDR: next_state_s = tms_i ? ST_SELDR : ST_RTI;
            ST_SELIR: next_state_s = tms_i ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: next_state_s = tms_i ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  next_state_s = tms_i ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: next_state_s = tms_i ? ST_UPDIR : ST_PAUIR;
            ST_PAUIR: next_state_s = tms_i ? ST_EX2IR : ST_PAUIR;
            ST_EX2IR: next_state_s = tms_i ? ST_UPDIR : ST_SHIR;
            ST_UPDIR: next_state_s = tms_i ? ST_SELDR : ST_RTI;
            default:  next_state_s = ST_TLR;
        endcase
    end

    assign test_logic_reset_o = (state_r == ST_TLR);
    assign capture_dr_o       = (state_r == ST_CAPDR);
    assign shift_dr_o         = (state_r == ST_SHDR);
    assign pause_dr_o         = (state_r == ST_PAUDR);
    assign update_dr_o        = (state_r == ST_UPDDR);
    assign tdo_en_o           = (state_r == ST_SHDR) || (state_r == ST_SHIR);

    // One-hot instruction decode; anything unrecognised falls back to BYPASS
    always_comb begin
        extest_select_o         = 1'b0;
        sample_preload_select_o = 1'b0;
        mbist_select_o          = 1'b0;
        debug_select_o          = 1'b0;
        idcode_select_o         = 1'b0;
        bypass_select_o         = 1'b0;
        if (ir_r == OP_EXTEST) begin
            extest_select_o = 1'b1;
        end else if (ir_r == OP_SAMPLE) begin
            sample_preload_select_o = 1'b1;
        end else if (ir_r == OP_IDCODE) begin
            idcode_select_o = 1'b1;
        end else if (ir_r == OP_MBIST) begin
            mbist_select_o = 1'b1;
        end else if (ir_r == OP_DEBUG) begin
            debug_select_o = 1'b1;
        end else begin
            bypass_select_o = 1'b1;
        end
    end

    // State register and instruction register path
    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            state_r    <= ST_TLR;
            ir_r       <= OP_IDCODE;
            ir_shift_r <= {IR_LEN{1'b0}};
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ST_CAPIR: ir_shift_r <= IR_LEN'(2'b01);
                ST_SHIR:  ir_shift_r <= {tdi_i, ir_shift_r[IR_LEN-1:1]};
                ST_UPDIR: ir_r       <= ir_shift_r;
                ST_TLR:   ir_r       <= OP_IDCODE;
                default:  ir_r       <= ir_r;
            endcase
        end
    end

    // IDCODE and BYPASS data registers; pause and update leave them untouched
    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            bypass_r       <= 1'b0;
            idcode_shift_r <= IDCODE_VAL;
        end else if (state_r == ST_CAPDR) begin
            if (bypass_select_o) bypass_r <= 1'b0;
            if (idcode_select_o) idcode_shift_r <= IDCODE_VAL;
        end else if (state_r == ST_SHDR) begin
            if (bypass_select_o) bypass_r <= tdi_i;
            if (idcode_select_o) idcode_shift_r <= {tdi_i, idcode_shift_r[31:1]};
        end else begin
            bypass_r <= bypass_r;
        end
    end

    // TDO source select; driven low outside the shift states
    always_comb begin
        tdo_s = 1'b0;
        case (state_r)
            ST_SHIR: tdo_s = ir_shift_r[0];
            ST_SHDR: begin
                if (idcode_select_o) begin
                    tdo_s = idcode_shift_r[0];
                end else if (extest_select_o || sample_preload_select_o) begin
                    tdo_s = bs_chain_tdo_i;
                end else if (mbist_select_o) begin
                    tdo_s = mbist_tdo_i;
                end else if (debug_select_o) begin
                    tdo_s = debug_tdo_i;
                end else begin
                    tdo_s = bypass_r;
                end
            end
            default: tdo_s = 1'b0;
        endcase
    end

    assign tdo_o = tdo_s;

endmodule
